// File: rtl/mem_pkg.sv
// Shared types, default parameters and byte-lane helpers for the data memory.
package mem_pkg;

  localparam int unsigned DEF_MEM_BYTES = 8192;
  localparam int unsigned DEF_LATENCY   = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT
  } mem_state_e;

  // Little-endian lanes: lane 0 is bits [7:0].
  function automatic logic [31:0] lane_select(input logic [31:0] word,
                                              input logic [1:0]  lane);
    return {24'b0, word[{lane, 3'b000} +: 8]};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = data;
    return merged;
  endfunction

  function automatic logic [31:0] init_word(input int unsigned index);
    return 32'hDEADBEEF + index;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between a requester and the data memory.
interface data_memory_if;

  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_store_byte;
  logic        mem_load_byte;
  logic [31:0] mem_read_data;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic        mem_busy;

  modport master (
    output mem_read_enable, mem_write_enable, mem_address, mem_write_data,
           mem_store_byte, mem_load_byte,
    input  mem_read_data, mem_read_valid, mem_write_valid, mem_busy
  );

  modport slave (
    input  mem_read_enable, mem_write_enable, mem_address, mem_write_data,
           mem_store_byte, mem_load_byte,
    output mem_read_data, mem_read_valid, mem_write_valid, mem_busy
  );

endinterface

// File: rtl/mem_latency_counter.sv
// Free-running request-age counter: clear has priority over enable.
module mem_latency_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_memory.sv
// Fixed-latency word/byte data memory with one outstanding request at a time.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
  parameter int unsigned LATENCY   = DEF_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  data_memory_if.slave bus
);

  localparam int unsigned      WORDS = MEM_BYTES / 4;
  localparam int unsigned      IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned      CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LATENCY - 1);

  mem_state_e       r_state;
  mem_state_e       w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_byte;
  logic             r_rvalid;
  logic             r_wvalid;
  logic             w_accept;
  logic             w_done;
  logic             w_read_done;
  logic             w_commit;
  logic [CNT_W-1:0] w_count;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [31:0]      w_mem [WORDS];

  mem_latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency (
    .clk      (clk),
    .i_clear  (reset || w_accept),
    .i_enable (r_state != IDLE),
    .o_count  (w_count)
  );

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.mem_read_enable) begin
          w_next   = READ_WAIT;
          w_accept = 1'b1;
        end else if (bus.mem_write_enable) begin
          w_next   = WRITE_WAIT;
          w_accept = 1'b1;
        end
      end
      READ_WAIT, WRITE_WAIT: begin
        if (w_count == LAST) begin
          w_next = IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Reset on the response edge aborts: no data update, no commit, no pulse.
  assign w_read_done = w_done && (r_state == READ_WAIT)  && !reset;
  assign w_commit    = w_done && (r_state == WRITE_WAIT) && !reset;

  assign w_idx  = IDX_W'({2'b00, r_addr[31:2]} % WORDS);
  assign w_word = w_mem[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rvalid <= 1'b0;
      r_wvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_rvalid <= w_read_done;
      r_wvalid <= w_commit;
      if (w_read_done) begin
        r_rdata <= r_byte ? lane_select(w_word, r_addr[1:0]) : w_word;
      end
    end
  end

  // Request capture needs no reset: it is only consumed after an acceptance.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= bus.mem_address;
      if (bus.mem_read_enable) begin
        r_byte <= bus.mem_load_byte;
      end else begin
        r_byte  <= bus.mem_store_byte;
        r_wdata <= bus.mem_write_data;
      end
    end
  end

  // Per-word registers carry their power-up contents; reset never touches them.
  for (genvar i = 0; i < WORDS; i++) begin : g_word
    logic [31:0] r_word = init_word(i);

    always_ff @(posedge clk) begin
      if (w_commit && (w_idx == IDX_W'(i))) begin
        r_word <= r_byte ? lane_merge(r_word, r_addr[1:0], r_wdata[7:0]) : r_wdata;
      end
    end

    assign w_mem[i] = r_word;
  end

  assign bus.mem_read_data   = r_rdata;
  assign bus.mem_read_valid  = r_rvalid;
  assign bus.mem_write_valid = r_wvalid;
  assign bus.mem_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against an array-based reference model.
module tb_data_memory;

  localparam int unsigned LAT    = 4;
  localparam int unsigned NWORDS = 2048;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_if bus ();

  data_memory #(
    .MEM_BYTES (8192),
    .LATENCY   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] model [NWORDS];

  initial begin
    for (int i = 0; i < NWORDS; i++) model[i] = 32'hDEADBEEF + i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % NWORDS;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic b);
    logic [31:0] w;
    w = model[widx(a)];
    if (b) return (w >> (8 * a[1:0])) & 32'hFF;
    return w;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic b);
    logic [31:0] mask;
    if (b) begin
      mask = 32'hFF << (8 * a[1:0]);
      model[widx(a)] = (model[widx(a)] & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
    end else begin
      model[widx(a)] = d;
    end
  endtask

  // Issues one request and observes the bus for a bounded window after acceptance.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic bflag,
                        output int rv_at, output int wv_at, output int rv_n,
                        output int wv_n, output int busy_n, output logic [31:0] rdata);
    rv_at = -1; wv_at = -1; rv_n = 0; wv_n = 0; busy_n = 0; rdata = '0;
    @(negedge clk);
    bus.mem_read_enable  = rd;
    bus.mem_write_enable = wr;
    bus.mem_address      = addr;
    bus.mem_write_data   = data;
    bus.mem_load_byte    = bflag;
    bus.mem_store_byte   = bflag;
    @(posedge clk); #1;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    if (bus.mem_busy) busy_n++;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(posedge clk); #1;
      if (bus.mem_busy) busy_n++;
      if (bus.mem_read_valid) begin
        rv_n++;
        if (rv_at < 0) begin rv_at = c; rdata = bus.mem_read_data; end
      end
      if (bus.mem_write_valid) begin
        wv_n++;
        if (wv_at < 0) wv_at = c;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.mem_read_valid !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", bus.mem_read_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_write_valid !== 1'b0) $display("FAIL rst_wvalid: got %b expected 0", bus.mem_write_valid); else pass_cnt++;
    total_cnt++; if (bus.mem_read_data !== 32'h0) $display("FAIL rst_rdata: got %h expected 00000000", bus.mem_read_data); else pass_cnt++;
    total_cnt++; if (bus.mem_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.mem_busy); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_read();
    int ra, wa, rn, wn, bn; logic [31:0] d;
    run_op(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (ra !== LAT) $display("FAIL rd0_latency: got %0d expected %0d", ra, LAT); else pass_cnt++;
    total_cnt++; if (rn !== 1 || wn !== 0) $display("FAIL rd0_pulses: got r=%0d w=%0d expected r=1 w=0", rn, wn); else pass_cnt++;
    total_cnt++; if (bn !== LAT) $display("FAIL rd0_busy_cycles: got %0d expected %0d", bn, LAT); else pass_cnt++;
    total_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL rd0_data: got %h expected deadbeef", d); else pass_cnt++;
  endtask

  task automatic test_word_write();
    int ra, wa, rn, wn, bn; logic [31:0] d;
    run_op(1'b0, 1'b1, 32'h4, 32'h12345678, 1'b0, ra, wa, rn, wn, bn, d);
    model_write(32'h4, 32'h12345678, 1'b0);
    total_cnt++; if (wa !== LAT) $display("FAIL wr4_latency: got %0d expected %0d", wa, LAT); else pass_cnt++;
    total_cnt++; if (wn !== 1 || rn !== 0) $display("FAIL wr4_pulses: got w=%0d r=%0d expected w=1 r=0", wn, rn); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'h12345678) $display("FAIL wr4_readback: got %h expected 12345678", d); else pass_cnt++;
  endtask

  task automatic test_byte_access();
    int ra, wa, rn, wn, bn; logic [31:0] d;
    run_op(1'b0, 1'b1, 32'h9, 32'hFFFFFFAB, 1'b1, ra, wa, rn, wn, bn, d);
    model_write(32'h9, 32'hFFFFFFAB, 1'b1);
    total_cnt++; if (wa !== LAT || wn !== 1) $display("FAIL sb9_valid: got at=%0d n=%0d expected at=%0d n=1", wa, wn, LAT); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'hDEADABF1) $display("FAIL sb9_word8: got %h expected deadabf1", d); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h9, 32'h0, 1'b1, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'h000000AB) $display("FAIL lb9_data: got %h expected 000000ab", d); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'hB, 32'h0, 1'b1, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'h000000DE) $display("FAIL lbB_data: got %h expected 000000de", d); else pass_cnt++;
  endtask

  task automatic test_read_write_together();
    int ra, wa, rn, wn, bn; logic [31:0] d;
    run_op(1'b1, 1'b1, 32'h10, 32'h55555555, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (rn !== 1 || wn !== 0 || ra !== LAT) $display("FAIL both_pulses: got r=%0d w=%0d at=%0d expected r=1 w=0 at=%0d", rn, wn, ra, LAT); else pass_cnt++;
    total_cnt++; if (d !== 32'hDEADBEF3) $display("FAIL both_data: got %h expected deadbef3", d); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'hDEADBEF3) $display("FAIL both_storage: got %h expected deadbef3", d); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int ra, wa, rn, wn, bn; int vn; logic [31:0] d;
    vn = 0;
    @(negedge clk);
    bus.mem_write_enable = 1'b1;
    bus.mem_address      = 32'h4;
    bus.mem_write_data   = 32'hCAFEF00D;
    bus.mem_store_byte   = 1'b0;
    @(posedge clk); #1;
    bus.mem_write_enable = 1'b0;
    total_cnt++; if (bus.mem_busy !== 1'b1) $display("FAIL abort_busy_pre: got %b expected 1", bus.mem_busy); else pass_cnt++;
    @(posedge clk); #1;
    if (bus.mem_read_valid || bus.mem_write_valid) vn++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total_cnt++; if (bus.mem_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.mem_busy); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      if (bus.mem_read_valid || bus.mem_write_valid) vn++;
      @(posedge clk); #1;
    end
    total_cnt++; if (vn !== 0) $display("FAIL abort_no_valid: got %0d pulses expected 0", vn); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== model_read(32'h4, 1'b0)) $display("FAIL abort_storage: got %h expected %h", d, model_read(32'h4, 1'b0)); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int ra, wa, rn, wn, bn; logic [31:0] d;
    run_op(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL wrap_read: got %h expected deadbeef", d); else pass_cnt++;
    run_op(1'b0, 1'b1, 32'h2004, 32'h0BADF00D, 1'b0, ra, wa, rn, wn, bn, d);
    model_write(32'h2004, 32'h0BADF00D, 1'b0);
    run_op(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== model_read(32'h4, 1'b0)) $display("FAIL wrap_write: got %h expected %h", d, model_read(32'h4, 1'b0)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ra, wa, rn, wn, bn; int rv_n, wv_n, hold_bad; logic [31:0] d, first, exp_a, exp_c;
    rv_n = 0; wv_n = 0; hold_bad = 0; first = '0;
    exp_a = model_read(32'h20, 1'b0);
    exp_c = model_read(32'h28, 1'b0);
    @(negedge clk);
    bus.mem_read_enable = 1'b1;
    bus.mem_load_byte   = 1'b0;
    bus.mem_address     = 32'h20;
    @(posedge clk); #1;
    // Write held while busy must be ignored, not queued.
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b1;
    bus.mem_store_byte   = 1'b0;
    bus.mem_address      = 32'h24;
    bus.mem_write_data   = 32'h11111111;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.mem_read_valid) rv_n++;
      if (bus.mem_write_valid) wv_n++;
      if (c == LAT) begin
        first = bus.mem_read_data;
        total_cnt++; if (bus.mem_read_valid !== 1'b1 || first !== exp_a) $display("FAIL b2b_first: got v=%b d=%h expected v=1 d=%h", bus.mem_read_valid, first, exp_a); else pass_cnt++;
        bus.mem_write_enable = 1'b0;
        bus.mem_read_enable  = 1'b1;
        bus.mem_address      = 32'h28;
      end else if (c == LAT + 1) begin
        bus.mem_read_enable = 1'b0;
      end
      if (c > LAT && c < 2 * LAT + 1 && (bus.mem_read_data !== exp_a || bus.mem_read_valid)) hold_bad++;
      if (c == 2 * LAT + 1) begin
        total_cnt++; if (bus.mem_read_valid !== 1'b1 || bus.mem_read_data !== exp_c) $display("FAIL b2b_second: got v=%b d=%h expected v=1 d=%h", bus.mem_read_valid, bus.mem_read_data, exp_c); else pass_cnt++;
      end
    end
    total_cnt++; if (hold_bad !== 0) $display("FAIL b2b_hold: got %0d bad cycles expected 0", hold_bad); else pass_cnt++;
    total_cnt++; if (rv_n !== 2 || wv_n !== 0) $display("FAIL b2b_pulses: got r=%0d w=%0d expected r=2 w=0", rv_n, wv_n); else pass_cnt++;
    run_op(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, ra, wa, rn, wn, bn, d);
    total_cnt++; if (d !== model_read(32'h24, 1'b0)) $display("FAIL b2b_ignored_write: got %h expected %h", d, model_read(32'h24, 1'b0)); else pass_cnt++;
  endtask

  task automatic test_random();
    int ra, wa, rn, wn, bn; logic [31:0] d, addr, data, exp; logic bflag; int unsigned op;
    for (int n = 0; n < 40; n++) begin
      op    = $urandom_range(0, 2);
      addr  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'h0000_3FFF);
      data  = $urandom;
      bflag = 1'($urandom_range(0, 1));
      run_op(op != 1, op != 0, addr, data, bflag, ra, wa, rn, wn, bn, d);
      if (op == 1) begin
        model_write(addr, data, bflag);
        total_cnt++; if (wa !== LAT || wn !== 1 || rn !== 0) $display("FAIL rand_write_%0d: got at=%0d w=%0d r=%0d expected at=%0d w=1 r=0", n, wa, wn, rn, LAT); else pass_cnt++;
      end else begin
        exp = model_read(addr, bflag);
        total_cnt++; if (ra !== LAT || rn !== 1 || wn !== 0) $display("FAIL rand_read_timing_%0d: got at=%0d r=%0d w=%0d expected at=%0d r=1 w=0", n, ra, rn, wn, LAT); else pass_cnt++;
        total_cnt++; if (d !== exp) $display("FAIL rand_read_data_%0d: addr %h byte %b got %h expected %h", n, addr, bflag, d, exp); else pass_cnt++;
      end
    end
  endtask

  initial begin
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_address      = '0;
    bus.mem_write_data   = '0;
    bus.mem_store_byte   = 1'b0;
    bus.mem_load_byte    = 1'b0;
    test_reset();
    test_word_read();
    test_word_write();
    test_byte_access();
    test_read_write_together();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
